// File: rtl/dly_chk_pkg.sv
// Shared types and constants for the delayed-response checker.
package dly_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } dly_chk_state_e;

    localparam int DLY_CHK_MAX_LATENCY = 8;
    localparam int DLY_CHK_DEF_SAMPLES = 16;

endpackage

// File: rtl/dly_chk_shift.sv
// LATENCY-deep 1-bit delay line; exp is din as captured LATENCY edges earlier.
// Cleared synchronously by the active-low rstn.
module dly_chk_shift #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic exp
);

    logic [LATENCY-1:0] sr;

    generate
        if (LATENCY == 1) begin : g_one
            // Single stage: capture din every edge, clear on reset
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sr <= '0;
                end else begin
                    sr <= din;
                end
            end
        end else begin : g_multi
            // Multi stage: shift din in at the bottom, oldest sample leaves at the top
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[LATENCY-2:0], din};
                end
            end
        end
    endgenerate

    assign exp = sr[LATENCY-1];

endmodule

// File: rtl/dly_resp_checker.sv
// Response checker: compares q_obs against d_ref delayed by LATENCY over
// SAMPLES compares and reports done/pass, per-compare mismatch pulses and a
// saturating error count. All outputs are registered and reset is
// synchronous active-low.
// Optional macro DLY_CHK_FIRST_ERR_EN adds first_err_idx/first_err_vld,
// which capture the 0-based index of the first failing compare of a run.
module dly_resp_checker
    import dly_chk_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int SAMPLES = DLY_CHK_DEF_SAMPLES,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             d_ref,
    input  logic             q_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
`ifdef DLY_CHK_FIRST_ERR_EN
    ,
    output logic [IDX_W-1:0] first_err_idx,
    output logic             first_err_vld
`endif
);

    localparam int SMP_W  = $clog2(SAMPLES + 1);
    localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dly_chk_state_e   state;
    logic [FILL_W-1:0] fill_cnt;
    logic [SMP_W-1:0]  smp_cnt;
    logic              exp;
    logic              miss;

    dly_chk_shift #(
        .LATENCY (LATENCY)
    ) u_shift (
        .clk  (clk),
        .rstn (rstn),
        .din  (d_ref),
        .exp  (exp)
    );

    assign miss = (q_obs != exp);

    // Run sequencer: fill the delay line, run SAMPLES compares, then hold results
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            fill_cnt <= '0;
            smp_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
`ifdef DLY_CHK_FIRST_ERR_EN
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
`endif
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                        smp_cnt  <= '0;
                        err_cnt  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
`ifdef DLY_CHK_FIRST_ERR_EN
                        first_err_idx <= '0;
                        first_err_vld <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (fill_cnt == FILL_W'(LATENCY - 1)) begin
                        state    <= CHECK;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (miss) begin
                        mismatch <= 1'b1;
                        if (err_cnt != CNT_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
`ifdef DLY_CHK_FIRST_ERR_EN
                        if (!first_err_vld) begin
                            first_err_idx <= smp_cnt[IDX_W-1:0];
                            first_err_vld <= 1'b1;
                        end
`endif
                    end
                    smp_cnt <= smp_cnt + 1'b1;
                    if (smp_cnt == SMP_W'(SAMPLES - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !miss;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dly_resp_checker.sv
// Bench for dly_resp_checker. Three instances share clock, reset, start and
// d_ref: a LATENCY=1 checker against a single-flop DUT (with optional bit
// inversion), a LATENCY=2 checker against the same flop, and a CNT_W=3
// checker fed the inverse of the flop output. Honours DLY_CHK_FIRST_ERR_EN.
module tb_dly_resp_checker;
    import dly_chk_pkg::*;

    logic clk;
    logic rstn;
    logic start;
    logic d_ref;
    logic inject;
    logic q_flop = 1'b0;
    logic q_obs;
    logic q_obs_sat;

    logic       busy, done, pass, mismatch;
    logic [7:0] err_cnt;
    logic       l2_busy, l2_done, l2_pass, l2_mismatch;
    logic [7:0] l2_err_cnt;
    logic       sat_busy, sat_done, sat_pass, sat_mismatch;
    logic [2:0] sat_err_cnt;
`ifdef DLY_CHK_FIRST_ERR_EN
    logic [3:0] first_err_idx, l2_first_err_idx, sat_first_err_idx;
    logic       first_err_vld, l2_first_err_vld, sat_first_err_vld;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int busy_cnt, done_edge, mm_seen, sat_pulses;
    logic busy0, done0, pass0;
    logic [7:0] err0;
    int exp_q[$];

    // The "DUT" under observation: a single flop on d_ref
    always_ff @(posedge clk) q_flop <= d_ref;

    assign q_obs     = q_flop ^ inject;
    assign q_obs_sat = ~q_flop;

    dly_resp_checker #(.LATENCY(1), .SAMPLES(16), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .d_ref(d_ref), .q_obs(q_obs),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .err_cnt(err_cnt)
`ifdef DLY_CHK_FIRST_ERR_EN
        , .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
`endif
    );

    dly_resp_checker #(.LATENCY(2), .SAMPLES(16), .CNT_W(8)) dut_l2 (
        .clk(clk), .rstn(rstn), .start(start), .d_ref(d_ref), .q_obs(q_flop),
        .busy(l2_busy), .done(l2_done), .pass(l2_pass), .mismatch(l2_mismatch), .err_cnt(l2_err_cnt)
`ifdef DLY_CHK_FIRST_ERR_EN
        , .first_err_idx(l2_first_err_idx), .first_err_vld(l2_first_err_vld)
`endif
    );

    dly_resp_checker #(.LATENCY(1), .SAMPLES(16), .CNT_W(3)) dut_sat (
        .clk(clk), .rstn(rstn), .start(start), .d_ref(d_ref), .q_obs(q_obs_sat),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .mismatch(sat_mismatch), .err_cnt(sat_err_cnt)
`ifdef DLY_CHK_FIRST_ERR_EN
        , .first_err_idx(sat_first_err_idx), .first_err_vld(sat_first_err_vld)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run of ncyc edges starting with a start pulse sampled on edge 0.
    // d_ref toggles 0,1,0,1...; bit k of inj_mask inverts q_obs for compare k,
    // whose mismatch pulse is expected right after edge k+2. extra_start > 0
    // adds a second start pulse sampled on that edge.
    task automatic drive_run(input logic [15:0] inj_mask, input int extra_start, input int ncyc);
        int e;
        busy_cnt   = 0;
        done_edge  = -1;
        mm_seen    = 0;
        sat_pulses = 0;
        exp_q.delete();
        start  = 1'b1;
        d_ref  = 1'b0;
        inject = 1'b0;
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) begin
                busy0 = busy;
                done0 = done;
                pass0 = pass;
                err0  = err_cnt;
            end
            if (busy) busy_cnt++;
            if (done && done_edge < 0) done_edge = j;
            if (sat_mismatch) sat_pulses++;
            if (mismatch) begin
                mm_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL mismatch_pulse: pulse seen after edge %0d, required no pulse", j);
                end else begin
                    e = exp_q.pop_front();
                    if (e != j) begin
                        n_fail++;
                        $display("[TB] FAIL mismatch_pulse: pulse after edge %0d, required after edge %0d", j, e);
                    end
                end
            end
            start = (j + 1 == extra_start);
            d_ref = (j + 1) % 2 == 1;
            inject = (j >= 1 && j <= 16) ? inj_mask[j-1] : 1'b0;
            if (inject) exp_q.push_back(j + 1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL mismatch_missing: %0d expected pulses never seen, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int done_seen;
        start  = 1'b0;
        d_ref  = 1'b0;
        inject = 1'b0;
        rstn   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, pass, mismatch, err_cnt, l2_busy, l2_done, sat_busy, sat_err_cnt} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b pass=%b mm=%b err=%0d, required all 0",
                     busy, done, pass, mismatch, err_cnt);
        end
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %0d, required IDLE", dut.state);
        end
        rstn  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_run_started: busy=%b, required 1", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        n_checks++;
        if ({busy, done, pass, mismatch, err_cnt, l2_busy, sat_busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset_outputs: got busy=%b done=%b pass=%b mm=%b err=%0d, required all 0",
                     busy, done, pass, mismatch, err_cnt);
        end
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset_state: got %0d, required IDLE", dut.state);
        end
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset_abandoned: busy/done high for %0d cycles, required 0", done_seen);
        end
    endtask

    task automatic test_clean_run();
        drive_run(16'h0000, -1, 20);
        n_checks++;
        if (busy_cnt != 17) begin
            n_fail++;
            $display("[TB] FAIL clean_busy_cycles: got %0d, required 17", busy_cnt);
        end
        n_checks++;
        if (done_edge != 17) begin
            n_fail++;
            $display("[TB] FAIL clean_done_edge: got %0d, required 17", done_edge);
        end
        n_checks++;
        if ({done, pass, err_cnt} !== {1'b1, 1'b1, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL clean_result: got done=%b pass=%b err=%0d, required done=1 pass=1 err=0",
                     done, pass, err_cnt);
        end
        n_checks++;
        if (mm_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL clean_mismatch_count: got %0d, required 0", mm_seen);
        end
    endtask

    task automatic test_injected_errors();
        drive_run(16'h0208, -1, 20);
        n_checks++;
        if (mm_seen != 2) begin
            n_fail++;
            $display("[TB] FAIL inject_pulse_count: got %0d, required 2", mm_seen);
        end
        n_checks++;
        if ({done, pass, err_cnt} !== {1'b1, 1'b0, 8'd2}) begin
            n_fail++;
            $display("[TB] FAIL inject_result: got done=%b pass=%b err=%0d, required done=1 pass=0 err=2",
                     done, pass, err_cnt);
        end
`ifdef DLY_CHK_FIRST_ERR_EN
        n_checks++;
        if ({first_err_vld, first_err_idx} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("[TB] FAIL inject_first_err: got vld=%b idx=%0d, required vld=1 idx=3",
                     first_err_vld, first_err_idx);
        end
`endif
    endtask

    task automatic test_start_in_done();
        drive_run(16'h0000, -1, 20);
        n_checks++;
        if ({busy0, done0, pass0, err0} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL restart_clear: got busy=%b done=%b pass=%b err=%0d, required busy=1 done=0 pass=0 err=0",
                     busy0, done0, pass0, err0);
        end
        n_checks++;
        if ({done, pass, err_cnt} !== {1'b1, 1'b1, 8'd0} || done_edge != 17) begin
            n_fail++;
            $display("[TB] FAIL restart_complete: got done=%b pass=%b err=%0d edge=%0d, required 1 1 0 edge 17",
                     done, pass, err_cnt, done_edge);
        end
`ifdef DLY_CHK_FIRST_ERR_EN
        n_checks++;
        if (first_err_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL restart_first_err_vld: got %b, required 0", first_err_vld);
        end
`endif
    endtask

    task automatic test_latency_mismatch();
        drive_run(16'h0000, -1, 20);
        n_checks++;
        if ({l2_done, l2_pass, l2_err_cnt} !== {1'b1, 1'b0, 8'd16}) begin
            n_fail++;
            $display("[TB] FAIL latency_result: got done=%b pass=%b err=%0d, required done=1 pass=0 err=16",
                     l2_done, l2_pass, l2_err_cnt);
        end
    endtask

    task automatic test_saturation();
        drive_run(16'h0000, -1, 20);
        n_checks++;
        if (sat_err_cnt !== 3'd7) begin
            n_fail++;
            $display("[TB] FAIL sat_err_cnt: got %0d, required 7", sat_err_cnt);
        end
        n_checks++;
        if (sat_pulses != 16) begin
            n_fail++;
            $display("[TB] FAIL sat_pulses: got %0d, required 16", sat_pulses);
        end
        n_checks++;
        if ({sat_done, sat_pass} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL sat_result: got done=%b pass=%b, required done=1 pass=0", sat_done, sat_pass);
        end
    endtask

    task automatic test_start_in_check();
        drive_run(16'h0000, 8, 20);
        n_checks++;
        if (busy_cnt != 17 || done_edge != 17) begin
            n_fail++;
            $display("[TB] FAIL check_start_ignored: got busy=%0d done_edge=%0d, required 17 and 17",
                     busy_cnt, done_edge);
        end
        n_checks++;
        if ({done, pass, err_cnt} !== {1'b1, 1'b1, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL check_start_result: got done=%b pass=%b err=%0d, required 1 1 0",
                     done, pass, err_cnt);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        rstn   = 1'b0;
        start  = 1'b0;
        d_ref  = 1'b0;
        inject = 1'b0;
        test_reset();
        test_clean_run();
        test_injected_errors();
        test_start_in_done();
        test_latency_mismatch();
        test_saturation();
        test_start_in_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
